// File: rtl/keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types, sizes and helpers for the matrix keypad scanner.
//             Holds the debounce FSM state encoding, the matrix geometry and
//             the snapshot helpers (popcount and one-hot to index).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int N_KEYS = N_ROWS * N_COLS;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Number of set bits in a full-matrix snapshot.
    function automatic logic [4:0] popcount16(input logic [N_KEYS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Index of the set bit; only meaningful when exactly one bit is set.
    function automatic logic [CODE_W-1:0] onehot_idx(input logic [N_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_if
//  Purpose  : Bundles the keypad matrix lines and the decoded key outputs.
//  Signals  : key_row     row returns into the scanner
//             key_col     one-hot column strobe
//             key_code    last accepted key (row*4 + col)
//             key_valid   1-cycle press-accepted pulse
//             key_held    high while the accepted key is held
//             key_release 1-cycle release-accepted pulse
//  Modports : master = scanner, slave = keypad / consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [N_ROWS-1:0] key_row;
    logic [N_COLS-1:0] key_col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;
    logic              key_release;

    modport master (
        input  key_row,
        output key_col, key_code, key_valid, key_held, key_release
    );

    modport slave (
        output key_row,
        input  key_col, key_code, key_valid, key_held, key_release
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Width-parameterised two-flop synchroniser for asynchronous
//             level inputs.
//  Ports    : clk   in  1      system clock
//             reset in  1      asynchronous, active-low
//             d     in  WIDTH  asynchronous input
//             q     out WIDTH  synchronised output
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : 4x4 matrix keypad scanner. Strobes columns one-hot, samples the
//             synchronised rows into a per-scan snapshot, debounces over whole
//             scans and reports an accepted key with press/release pulses.
//  Ports    : clk    in  1  system clock
//             reset  in  1  asynchronous, active-low
//             kp     keypad_scan_if.master (key_row in; key_col, key_code,
//                    key_valid, key_held, key_release out)
//  Params   : SCAN_DIV        clk cycles per column step (>=4)
//             DEBOUNCE_SCANS  consecutive scans to accept press/release (>=2)
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [N_ROWS-1:0] row_sync;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [N_COLS-1:0] col_q, col_d;
    logic [N_KEYS-1:0] snap_q, snap_d;
    state_t            state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              release_q, release_d;

    logic              tick;
    logic              scan_end;
    logic [N_KEYS-1:0] snap_full;
    logic [4:0]        pop;
    logic              is_single;
    logic [CODE_W-1:0] single_idx;
    logic              cand_set;
    logic              cnt_done;
    logic [CNT_W-1:0]  cnt_inc;

    sync_2ff #(.WIDTH(N_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.key_row),
        .q     (row_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            col_q     <= 4'b0001;
            snap_q    <= '0;
            state_q   <= IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            release_q <= release_d;
        end
    end

    // Divider, column ring and snapshot capture.
    always_comb begin
        tick     = (div_q == DIV_LAST);
        scan_end = tick && col_q[N_COLS-1];
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        col_d    = tick ? {col_q[N_COLS-2:0], col_q[N_COLS-1]} : col_q;

        // The last column's sample lands on the scan-end edge itself, so the
        // evaluated snapshot merges the live sample with the stored bits.
        snap_full = snap_q;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (col_q[c]) begin
                    snap_full[r*N_COLS + c] = row_sync[r];
                end
            end
        end

        if (scan_end) begin
            snap_d = '0;
        end else if (tick) begin
            snap_d = snap_full;
        end else begin
            snap_d = snap_q;
        end
    end

    // Classifier and debounce FSM; acts only at scan end.
    always_comb begin
        pop        = popcount16(snap_full);
        is_single  = (pop == 5'd1);
        single_idx = onehot_idx(snap_full);
        cand_set   = snap_full[cand_q];
        cnt_done   = (cnt_q == CNT_LAST);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        held_d    = held_q;
        valid_d   = 1'b0;
        release_d = 1'b0;

        if (scan_end) begin
            unique case (state_q)
                IDLE: begin
                    if (is_single) begin
                        state_d = DEBOUNCE;
                        cand_d  = single_idx;
                        cnt_d   = CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!is_single) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (single_idx != cand_q) begin
                        cand_d = single_idx;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_done) begin
                        state_d = PRESSED;
                        code_d  = cand_q;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    // Extra keys are tolerated while the accepted key stays down.
                    if (!cand_set) begin
                        state_d = RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cand_set) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_done) begin
                        state_d   = IDLE;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign kp.key_col     = col_q;
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_held    = held_q;
    assign kp.key_release = release_q;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan
//  Purpose  : Directed self-checking bench for keypad_scan (SCAN_DIV=4,
//             DEBOUNCE_SCANS=3, one scan = 16 clk). Key model drives
//             key_row[r] from key_col[c] for every pressed key (r,c).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;
    logic        clk;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  row_v;
    int          n_checks;
    int          n_fail;
    int          valid_cnt;
    int          rel_cnt;

    keypad_scan_if kp_if ();

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_v = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && kp_if.key_col[c]) begin
                    row_v[r] = 1'b1;
                end
            end
        end
    end
    assign kp_if.key_row = row_v;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (kp_if.key_valid)   valid_cnt = valid_cnt + 1;
        if (kp_if.key_release) rel_cnt   = rel_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        valid_cnt = 0;
        rel_cnt   = 0;
        keys      = '0;
        reset     = 1'b0;

        // 1: reset values, then column rotation
        step(3);
        chk("rst_col",     32'(kp_if.key_col), 32'h1);
        chk("rst_code",    32'(kp_if.key_code), 32'h0);
        chk("rst_valid",   32'(kp_if.key_valid), 32'h0);
        chk("rst_held",    32'(kp_if.key_held), 32'h0);
        chk("rst_release", 32'(kp_if.key_release), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(3);  chk("col_e3",  32'(kp_if.key_col), 32'h1);
        step(1);  chk("col_e4",  32'(kp_if.key_col), 32'h2);
        step(4);  chk("col_e8",  32'(kp_if.key_col), 32'h4);
        step(4);  chk("col_e12", 32'(kp_if.key_col), 32'h8);
        step(4);  chk("col_e16", 32'(kp_if.key_col), 32'h1);

        // 2: hold key 9 (r2,c1) for 6 scans
        keys = 16'h0200;
        step(47);
        chk("k9_valid_early", 32'(kp_if.key_valid), 32'h0);
        chk("k9_held_early",  32'(kp_if.key_held), 32'h0);
        step(1);
        chk("k9_valid", 32'(kp_if.key_valid), 32'h1);
        chk("k9_code",  32'(kp_if.key_code), 32'h9);
        chk("k9_held",  32'(kp_if.key_held), 32'h1);
        step(1);
        chk("k9_valid_1cyc", 32'(kp_if.key_valid), 32'h0);
        step(47);
        chk("k9_one_pulse", 32'(valid_cnt), 32'd1);
        chk("k9_still_held", 32'(kp_if.key_held), 32'h1);

        // 3: release key 9
        keys = '0;
        step(47);
        chk("k9_rel_early", 32'(kp_if.key_release), 32'h0);
        chk("k9_held_pre",  32'(kp_if.key_held), 32'h1);
        step(1);
        chk("k9_release",   32'(kp_if.key_release), 32'h1);
        chk("k9_held_off",  32'(kp_if.key_held), 32'h0);
        chk("k9_code_kept", 32'(kp_if.key_code), 32'h9);
        step(1);
        chk("k9_rel_1cyc", 32'(kp_if.key_release), 32'h0);
        chk("k9_rel_count", 32'(rel_cnt), 32'd1);
        step(15);

        // 4: bouncing key 0, then a clean hold
        for (int i = 0; i < 4; i++) begin
            keys = 16'h0001;
            step(16);
            keys = '0;
            step(16);
        end
        chk("bounce_no_valid", 32'(valid_cnt), 32'd1);
        keys = 16'h0001;
        step(47);
        chk("k0_valid_early", 32'(kp_if.key_valid), 32'h0);
        step(1);
        chk("k0_valid", 32'(kp_if.key_valid), 32'h1);
        chk("k0_code",  32'(kp_if.key_code), 32'h0);
        step(16);
        keys = '0;
        step(48);
        chk("k0_release", 32'(kp_if.key_release), 32'h1);
        chk("k0_held_off", 32'(kp_if.key_held), 32'h0);
        step(16);

        // 5: key 5 held, key 6 added, then a one-scan dropout of key 5
        keys = 16'h0020;
        step(48);
        chk("k5_valid", 32'(kp_if.key_valid), 32'h1);
        chk("k5_code",  32'(kp_if.key_code), 32'h5);
        step(16);
        keys = 16'h0060;
        step(32);
        chk("k56_no_valid", 32'(valid_cnt), 32'd3);
        chk("k56_code",     32'(kp_if.key_code), 32'h5);
        chk("k56_held",     32'(kp_if.key_held), 32'h1);
        keys = 16'h0040;
        step(16);
        keys = 16'h0020;
        step(32);
        chk("drop_no_release", 32'(rel_cnt), 32'd2);
        chk("drop_no_valid",   32'(valid_cnt), 32'd3);
        chk("drop_held",       32'(kp_if.key_held), 32'h1);
        keys = '0;
        step(48);
        chk("k5_release", 32'(kp_if.key_release), 32'h1);
        chk("k5_code_kept", 32'(kp_if.key_code), 32'h5);

        // 6: two keys from IDLE, then reset during debounce
        keys = 16'h8001;
        step(80);
        chk("multi_no_valid", 32'(valid_cnt), 32'd3);
        chk("multi_held",     32'(kp_if.key_held), 32'h0);
        keys = 16'h0008;
        step(32);
        reset = 1'b0;
        #1;
        chk("mid_rst_col",  32'(kp_if.key_col), 32'h1);
        chk("mid_rst_code", 32'(kp_if.key_code), 32'h0);
        chk("mid_rst_held", 32'(kp_if.key_held), 32'h0);
        keys = '0;
        step(3);
        @(negedge clk);
        reset = 1'b1;
        step(64);
        chk("post_rst_valid", 32'(valid_cnt), 32'd3);
        chk("post_rst_rel",   32'(rel_cnt), 32'd3);
        chk("post_rst_held",  32'(kp_if.key_held), 32'h0);
        chk("post_rst_code",  32'(kp_if.key_code), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
